// File: rtl/fiber_test_ctrl_if.sv
// Result readout channel of fiber_test_ctrl: one captured test outcome per transfer.
// result_valid rises when a result is ready, and the res_* fields are stable while it is high.
// The result is consumed on any rising edge where result_valid and result_ack are both high.
// After that edge result_valid drops. result_ack has no effect while result_valid is low.
interface fiber_test_ctrl_if;
  logic        result_valid;
  logic        result_ack;
  logic [31:0] res_samples;
  logic [31:0] res_errors;
  logic [1:0]  res_status;

  modport master (
    output result_valid,
    output res_samples,
    output res_errors,
    output res_status,
    input  result_ack
  );

  modport slave (
    input  result_valid,
    input  res_samples,
    input  res_errors,
    input  res_status,
    output result_ack
  );
endinterface

// File: rtl/fiber_test_ctrl.sv
// Sequencer for one fiber-input link test: acquire pattern lock, clear the checker,
// run for a programmed time, then capture and report the checker counters.
module fiber_test_ctrl #(
  parameter int unsigned LOCK_LEN     = 16,
  parameter int unsigned LOCK_TIMEOUT = 1048576,
  parameter int unsigned DRAIN_CYC    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       duration,
  input  logic [15:0]       data_in,
  input  logic [31:0]       chk_sample_cnt,
  input  logic [31:0]       chk_err_cnt,
  output logic              chk_rst,
  output logic              busy,
  output logic              locked,
  output logic [2:0]        state_dbg,
  fiber_test_ctrl_if.master res
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_CLEAR   = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_REPORT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] prev_word_q, prev_word_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic        chk_rst_q, chk_rst_d;
  logic        busy_q, busy_d;
  logic        locked_q, locked_d;
  logic        result_valid_q, result_valid_d;
  logic [31:0] res_samples_q, res_samples_d;
  logic [31:0] res_errors_q, res_errors_d;
  logic [1:0]  res_status_q, res_status_d;

  logic [15:0] word_diff;
  logic        good_word;
  logic [16:0] lock_inc;
  logic [TW:0] to_inc;

  always_comb begin
    word_diff      = data_in - prev_word_q;
    good_word      = (word_diff == 16'h0001);
    lock_inc       = {1'b0, lock_cnt_q} + 17'd1;
    to_inc         = {1'b0, to_cnt_q} + {{TW{1'b0}}, 1'b1};

    state_d        = state_q;
    prev_word_d    = data_in;
    lock_cnt_d     = lock_cnt_q;
    to_cnt_d       = to_cnt_q;
    run_cnt_d      = run_cnt_q;
    drain_cnt_d    = drain_cnt_q;
    res_samples_d  = res_samples_q;
    res_errors_d   = res_errors_q;
    res_status_d   = res_status_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_cnt_d  = (duration == 32'd0) ? 32'd1 : duration;
          lock_cnt_d = '0;
          to_cnt_d   = '0;
          state_d    = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        lock_cnt_d = good_word ? lock_inc[15:0] : 16'd0;
        // Lock is tested first so it wins over a timeout on the same edge.
        if (good_word && (lock_inc == 17'(LOCK_LEN))) begin
          state_d = S_CLEAR;
        end else begin
          to_cnt_d = to_inc[TW-1:0];
          if (to_inc == (TW+1)'(LOCK_TIMEOUT)) begin
            res_samples_d = 32'd0;
            res_errors_d  = 32'd0;
            res_status_d  = 2'd2;
            state_d       = S_REPORT;
          end
        end
      end
      S_CLEAR: begin
        drain_cnt_d = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        run_cnt_d   = run_cnt_q - 32'd1;
        drain_cnt_d = '0;
        if (run_cnt_q == 32'd1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
          res_samples_d = chk_sample_cnt;
          res_errors_d  = chk_err_cnt;
          res_status_d  = (chk_err_cnt == 32'd0) ? 2'd0 : 2'd1;
          state_d       = S_REPORT;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_REPORT: begin
        if (res.result_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
    end

    // Outputs are decoded from the next state so each flop changes on the entering edge.
    chk_rst_d      = (state_d == S_CLEAR);
    busy_d         = (state_d != S_IDLE);
    locked_d       = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    result_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      prev_word_q    <= '0;
      lock_cnt_q     <= '0;
      to_cnt_q       <= '0;
      run_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      chk_rst_q      <= 1'b0;
      busy_q         <= 1'b0;
      locked_q       <= 1'b0;
      result_valid_q <= 1'b0;
      res_samples_q  <= '0;
      res_errors_q   <= '0;
      res_status_q   <= '0;
    end else begin
      state_q        <= state_d;
      prev_word_q    <= prev_word_d;
      lock_cnt_q     <= lock_cnt_d;
      to_cnt_q       <= to_cnt_d;
      run_cnt_q      <= run_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      chk_rst_q      <= chk_rst_d;
      busy_q         <= busy_d;
      locked_q       <= locked_d;
      result_valid_q <= result_valid_d;
      res_samples_q  <= res_samples_d;
      res_errors_q   <= res_errors_d;
      res_status_q   <= res_status_d;
    end
  end

  assign chk_rst          = chk_rst_q;
  assign busy             = busy_q;
  assign locked           = locked_q;
  assign state_dbg        = state_q;
  assign res.result_valid = result_valid_q;
  assign res.res_samples  = res_samples_q;
  assign res.res_errors   = res_errors_q;
  assign res.res_status   = res_status_q;

endmodule

// File: tb/tb_fiber_test_ctrl.sv
// Bench for fiber_test_ctrl: drives pattern streams and a stub checker, and compares
// reported results against a queue of expected outcomes and measured cycle counts.
module tb_fiber_test_ctrl;

  localparam int unsigned LOCK_LEN     = 16;
  localparam int unsigned LOCK_TIMEOUT = 64;
  localparam int unsigned DRAIN_CYC    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] duration;
  logic [15:0] data_in;
  logic [31:0] chk_sample_cnt;
  logic [31:0] chk_err_cnt;
  logic        chk_rst;
  logic        busy;
  logic        locked;
  logic [2:0]  state_dbg;

  fiber_test_ctrl_if res_if();

  fiber_test_ctrl #(
    .LOCK_LEN    (LOCK_LEN),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .DRAIN_CYC   (DRAIN_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .duration      (duration),
    .data_in       (data_in),
    .chk_sample_cnt(chk_sample_cnt),
    .chk_err_cnt   (chk_err_cnt),
    .chk_rst       (chk_rst),
    .busy          (busy),
    .locked        (locked),
    .state_dbg     (state_dbg),
    .res           (res_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard entry: {status, errors, samples}
  logic [65:0] exp_q[$];

  // monitor, sampled on the falling edge
  int   cyc          = 0;
  int   start_cyc    = 0;
  int   chk_hi       = 0;
  int   chk_rise_cyc = 0;
  int   locked_hi    = 0;
  int   rv_rises     = 0;
  int   rv_rise_cyc  = 0;
  logic chk_prev     = 1'b0;
  logic rv_prev      = 1'b0;

  always @(negedge clk) begin
    logic [65:0] e;
    cyc++;
    if (start && !busy && !rst) start_cyc = cyc;
    if (chk_rst) begin
      chk_hi++;
      if (!chk_prev) chk_rise_cyc = cyc;
    end
    if (locked) locked_hi++;
    if (res_if.result_valid && !rv_prev) begin
      rv_rise_cyc = cyc;
      rv_rises++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_samples", res_if.res_samples, e[31:0]);
        check("res_errors",  res_if.res_errors,  e[63:32]);
        check("res_status",  32'(res_if.res_status), 32'(e[65:64]));
      end
    end
    chk_prev = chk_rst;
    rv_prev  = res_if.result_valid;
  end

  // driver state
  bit          data_const = 1'b0;
  int          glitch_cnt = 0;
  logic [31:0] last_s = 0, last_e = 0;
  logic [1:0]  last_st = 0;

  // One clock: the stub sample counter clears when the checker reset was high.
  task automatic tick();
    logic rs;
    rs = chk_rst;
    @(posedge clk);
    #1;
    chk_sample_cnt = rs ? 32'd0 : chk_sample_cnt + 32'd1;
    if (!data_const) begin
      data_in = (glitch_cnt == 1) ? data_in + 16'h0011 : data_in + 16'h0001;
    end
    if (glitch_cnt > 0) glitch_cnt--;
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [31:0] er, input logic [31:0] sm);
    exp_q.push_back({st, er, sm});
    last_st = st;
    last_e  = er;
    last_s  = sm;
  endtask

  task automatic pulse_start(input logic [15:0] w0, input logic [31:0] dur);
    data_in  = w0;
    duration = dur;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int snap, input int budget);
    int n = 0;
    while (rv_rises == snap && n < budget) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_result_seen"}, 32'(rv_rises != snap), 32'd1);
  endtask

  task automatic wait_lock(input string tag, input int snap, input int budget);
    int n = 0;
    while (chk_hi == snap && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_lock_seen"}, 32'(chk_hi != snap), 32'd1);
  endtask

  // Full test: lock, run, report with ack held high; timing checked from monitor counts.
  task automatic run_test(input string tag, input logic [15:0] w0, input logic [31:0] dur,
                          input logic [31:0] err, input int glitch, input bit constant,
                          input int exp_lock_lat);
    int s_chk, s_lock, s_rv;
    logic [31:0] d_eff;
    s_chk  = chk_hi;
    s_lock = locked_hi;
    s_rv   = rv_rises;
    d_eff  = (dur == 32'd0) ? 32'd1 : dur;
    data_const  = constant;
    glitch_cnt  = glitch;
    chk_err_cnt = err;
    if (constant) push_exp(2'd2, 32'd0, 32'd0);
    else          push_exp((err == 32'd0) ? 2'd0 : 2'd1, err, d_eff + 32'd1);
    pulse_start(w0, dur);
    wait_result(tag, s_rv, 400);
    repeat (2) tick();
    if (constant) begin
      check({tag, "_no_chk_rst"}, 32'(chk_hi - s_chk), 32'd0);
      check({tag, "_timeout_lat"}, 32'(rv_rise_cyc - start_cyc), 32'(LOCK_TIMEOUT + 1));
    end else begin
      check({tag, "_chk_rst_width"}, 32'(chk_hi - s_chk), 32'd1);
      check({tag, "_lock_lat"}, 32'(chk_rise_cyc - start_cyc), 32'(exp_lock_lat));
      check({tag, "_locked_cycles"}, 32'(locked_hi - s_lock), d_eff + 32'(1 + DRAIN_CYC));
      check({tag, "_report_lat"}, 32'(rv_rise_cyc - chk_rise_cyc), d_eff + 32'(1 + DRAIN_CYC));
    end
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    data_const = 1'b0;
  endtask

  initial begin
    int s_chk, s_lock, s_rv;
    rst = 1'b1; start = 1'b0; abort = 1'b0; duration = 32'd0;
    data_in = 16'd0; chk_sample_cnt = 32'd0; chk_err_cnt = 32'd0;
    res_if.result_ack = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    data_in = 16'd0;
    tick();

    check("rst_busy",    32'(busy), 32'd0);
    check("rst_locked",  32'(locked), 32'd0);
    check("rst_chk_rst", 32'(chk_rst), 32'd0);
    check("rst_valid",   32'(res_if.result_valid), 32'd0);
    check("rst_samples", res_if.res_samples, 32'd0);
    check("rst_errors",  res_if.res_errors, 32'd0);
    check("rst_status",  32'(res_if.res_status), 32'd0);

    run_test("basic",   16'h0000, 32'd100, 32'd0, 0,  1'b0, LOCK_LEN + 1);
    run_test("wrap",    16'hFFF7, 32'd5,   32'd0, 0,  1'b0, LOCK_LEN + 1);
    run_test("glitch",  16'h0100, 32'd8,   32'd0, 15, 1'b0, 15 + LOCK_LEN + 1);
    run_test("timeout", 16'h1234, 32'd10,  32'd0, 0,  1'b1, 0);
    run_test("dur0",    16'h0200, 32'd0,   32'd5, 0,  1'b0, LOCK_LEN + 1);
    run_test("rand",    16'($urandom_range(0, 65535)), 32'($urandom_range(2, 40)),
             32'($urandom_range(0, 9)), 0, 1'b0, LOCK_LEN + 1);

    // start during RUN is dropped, not queued
    s_lock = locked_hi; s_rv = rv_rises; s_chk = chk_hi;
    chk_err_cnt = 32'd0;
    push_exp(2'd0, 32'd0, 32'd21);
    pulse_start(16'h0040, 32'd20);
    wait_lock("srun", s_chk, 100);
    repeat (5) tick();
    duration = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_result("srun", s_rv, 200);
    repeat (6) tick();
    check("srun_locked_cycles", 32'(locked_hi - s_lock), 32'(20 + 1 + DRAIN_CYC));
    check("srun_one_result",    32'(rv_rises - s_rv), 32'd1);
    check("srun_not_queued",    32'(busy), 32'd0);

    // abort mid-RUN keeps the previous result
    s_rv = rv_rises; s_chk = chk_hi;
    chk_err_cnt = 32'd7;
    pulse_start(16'h0000, 32'd50);
    wait_lock("abort", s_chk, 100);
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",    32'(busy), 32'd0);
    check("abort_locked",  32'(locked), 32'd0);
    check("abort_chk_rst", 32'(chk_rst), 32'd0);
    check("abort_samples", res_if.res_samples, last_s);
    check("abort_errors",  res_if.res_errors, last_e);
    check("abort_status",  32'(res_if.res_status), 32'(last_st));
    repeat (80) tick();
    check("abort_no_result", 32'(rv_rises - s_rv), 32'd0);

    // rst while holding a result in REPORT
    res_if.result_ack = 1'b0;
    s_rv = rv_rises;
    chk_err_cnt = 32'd3;
    push_exp(2'd1, 32'd3, 32'd5);
    pulse_start(16'h0300, 32'd4);
    wait_result("rstrep", s_rv, 200);
    repeat (3) tick();
    check("rstrep_held_valid", 32'(res_if.result_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrep_valid",   32'(res_if.result_valid), 32'd0);
    check("rstrep_samples", res_if.res_samples, 32'd0);
    check("rstrep_errors",  res_if.res_errors, 32'd0);
    check("rstrep_status",  32'(res_if.res_status), 32'd0);
    check("rstrep_busy",    32'(busy), 32'd0);
    res_if.result_ack = 1'b1;
    repeat (2) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
